// File: rtl/display_buffer_swap_ctrl.sv
// Avalon-MM front/back frame-buffer swap sequencer for the LED tile scan engine.
// Optional: define DISPLAY_SWAP_IRQ_EN to add the irq output and the CTRL irq_mask bit.
module display_buffer_swap_ctrl #(
    parameter int NUM_BUF      = 2,
    parameter int BUF_W        = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic             frame_end,
    output logic [BUF_W-1:0] front_sel,
    output logic             blank,
    output logic             swap_pulse
`ifdef DISPLAY_SWAP_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int BC_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   front_sel_q, front_sel_d;
    logic               swap_pulse_q, swap_pulse_d;
    logic [BC_W-1:0]    blank_cnt_q, blank_cnt_d;
    logic               req_latch_q, req_latch_d;
    logic               auto_q, auto_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   swap_cnt_q, swap_cnt_d;
`ifdef DISPLAY_SWAP_IRQ_EN
    logic               irq_mask_q, irq_mask_d;
`endif

    logic wr, wr_ctrl, req_wr;
    logic unused_wdata;

    assign wr      = chipselect & ~write_n;
    assign wr_ctrl = wr & (address == 2'd0);
    assign req_wr  = wr_ctrl & writedata[0];

`ifdef DISPLAY_SWAP_IRQ_EN
    assign unused_wdata = ^{writedata[31:17], writedata[15:3]};
`else
    assign unused_wdata = ^{writedata[31:17], writedata[15:2]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            front_sel_q  <= '0;
            swap_pulse_q <= 1'b0;
            blank_cnt_q  <= '0;
            req_latch_q  <= 1'b0;
            auto_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_cnt_q  <= '0;
            swap_cnt_q   <= '0;
`ifdef DISPLAY_SWAP_IRQ_EN
            irq_mask_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            swap_pulse_q <= swap_pulse_d;
            blank_cnt_q  <= blank_cnt_d;
            req_latch_q  <= req_latch_d;
            auto_q       <= auto_d;
            done_q       <= done_d;
            frame_cnt_q  <= frame_cnt_d;
            swap_cnt_q   <= swap_cnt_d;
`ifdef DISPLAY_SWAP_IRQ_EN
            irq_mask_q   <= irq_mask_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        swap_pulse_d = 1'b0;
        blank_cnt_d  = blank_cnt_q;
        req_latch_d  = req_latch_q;
        auto_d       = auto_q;
        done_d       = done_q;
`ifdef DISPLAY_SWAP_IRQ_EN
        irq_mask_d   = irq_mask_q;
`endif

        if (wr && (address == 2'd1) && writedata[16]) begin
            done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // frame_end in this cycle is deliberately ignored; the swap waits for the next one
                if (req_wr || auto_q) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (frame_end) begin
                    state_d      = BLANK;
                    front_sel_d  = (front_sel_q == BUF_W'(NUM_BUF - 1)) ? '0 : front_sel_q + 1'b1;
                    swap_pulse_d = 1'b1;
                    blank_cnt_d  = BC_W'(BLANK_CYCLES - 1);
                    done_d       = 1'b1;
                end
            end
            BLANK: begin
                if (blank_cnt_q == '0) begin
                    state_d     = (req_latch_q || req_wr || auto_q) ? ARMED : IDLE;
                    req_latch_d = 1'b0;
                end else begin
                    blank_cnt_d = blank_cnt_q - 1'b1;
                    if (req_wr) begin
                        req_latch_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_ctrl) begin
            auto_d = writedata[1];
`ifdef DISPLAY_SWAP_IRQ_EN
            irq_mask_d = writedata[2];
`endif
        end
    end

    // Counter clears take priority over a same-cycle increment
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        swap_cnt_d  = swap_cnt_q;
        if (wr && (address == 2'd2)) begin
            frame_cnt_d = '0;
        end else if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (wr && (address == 2'd3)) begin
            swap_cnt_d = '0;
        end else if (swap_pulse_q) begin
            swap_cnt_d = swap_cnt_q + 1'b1;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[0] = (state_q == ARMED) | req_latch_q;
                readdata[1] = auto_q;
`ifdef DISPLAY_SWAP_IRQ_EN
                readdata[2] = irq_mask_q;
`endif
            end
            2'd1: begin
                readdata[BUF_W-1:0] = front_sel_q;
                readdata[8]         = (state_q == BLANK);
                readdata[16]        = done_q;
            end
            2'd2: readdata[CNT_W-1:0] = frame_cnt_q;
            2'd3: readdata[CNT_W-1:0] = swap_cnt_q;
            default: readdata = '0;
        endcase
    end

    assign front_sel  = front_sel_q;
    assign blank      = (state_q == BLANK);
    assign swap_pulse = swap_pulse_q;
`ifdef DISPLAY_SWAP_IRQ_EN
    assign irq        = done_q & irq_mask_q;
`endif

endmodule

// File: tb/tb_display_buffer_swap_ctrl.sv
// Bench for display_buffer_swap_ctrl: per-cycle model comparison plus directed literal checks.
// Builds with or without DISPLAY_SWAP_IRQ_EN.
module tb_display_buffer_swap_ctrl;

    localparam int NB = 3;
    localparam int BC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        frame_end = 1'b0;
    logic [1:0]  front_sel;
    logic        blank;
    logic        swap_pulse;
`ifdef DISPLAY_SWAP_IRQ_EN
    logic        irq;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    display_buffer_swap_ctrl #(
        .NUM_BUF(NB),
        .BUF_W(2),
        .BLANK_CYCLES(BC),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .frame_end(frame_end),
        .front_sel(front_sel),
        .blank(blank),
        .swap_pulse(swap_pulse)
`ifdef DISPLAY_SWAP_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    // Behavioural model: a pending-swap flag, blank cycles left, and plain counters
    int          m_front = 0;
    bit          m_armed = 0;
    int          m_blank_left = 0;
    bit          m_again = 0;
    bit          m_auto = 0;
    bit          m_mask = 0;
    bit          m_done = 0;
    bit          m_pulse = 0;
    logic [15:0] m_frames = 16'd0;
    logic [15:0] m_swaps = 16'd0;

    wire bus_wr  = chipselect && !write_n;
    wire req_now = bus_wr && (address == 2'd0) && writedata[0];
    wire swap_now = m_armed && (m_blank_left == 0) && frame_end;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_front      <= 0;
            m_armed      <= 0;
            m_blank_left <= 0;
            m_again      <= 0;
            m_auto       <= 0;
            m_mask       <= 0;
            m_done       <= 0;
            m_pulse      <= 0;
            m_frames     <= 16'd0;
            m_swaps      <= 16'd0;
        end else begin
            if (m_blank_left > 0) begin
                m_blank_left <= m_blank_left - 1;
                if (m_blank_left == 1) begin
                    m_armed <= m_again || req_now || m_auto;
                    m_again <= 0;
                end else if (req_now) begin
                    m_again <= 1;
                end
            end else if (m_armed) begin
                if (frame_end) begin
                    m_armed      <= 0;
                    m_front      <= (m_front + 1) % NB;
                    m_blank_left <= BC;
                end
            end else if (req_now || m_auto) begin
                m_armed <= 1;
            end
            m_pulse  <= swap_now;
            m_done   <= swap_now ? 1'b1 :
                        ((bus_wr && address == 2'd1 && writedata[16]) ? 1'b0 : m_done);
            m_frames <= (bus_wr && address == 2'd2) ? 16'd0 : m_frames + 16'(frame_end);
            m_swaps  <= (bus_wr && address == 2'd3) ? 16'd0 : m_swaps + 16'(m_pulse);
            if (bus_wr && address == 2'd0) begin
                m_auto <= writedata[1];
`ifdef DISPLAY_SWAP_IRQ_EN
                m_mask <= writedata[2];
`endif
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: r = {29'd0, m_mask, m_auto, (m_armed | m_again)};
            2'd1: r = 32'(m_front) | ((m_blank_left > 0) ? 32'h100 : 32'h0) | (m_done ? 32'h10000 : 32'h0);
            2'd2: r = {16'd0, m_frames};
            default: r = {16'd0, m_swaps};
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_front_sel", {30'd0, front_sel}, 32'(m_front));
        check("cyc_blank", {31'd0, blank}, {31'd0, (m_blank_left > 0)});
        check("cyc_swap_pulse", {31'd0, swap_pulse}, {31'd0, m_pulse});
        check("cyc_readdata", readdata, model_read(address));
`ifdef DISPLAY_SWAP_IRQ_EN
        check("cyc_irq", {31'd0, irq}, {31'd0, m_done & m_mask});
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic fe);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        frame_end  = fe;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        frame_end  = 1'b0;
        writedata  = 32'd0;
    endtask

    task automatic pulse_fe();
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
    endtask

    int exp_seq[4] = '{1, 2, 0, 1};

    initial begin
        // Reset state
        #1 reset_n = 1'b0;
        tick(1);
        for (int a = 0; a < 4; a++) rd_check(2'(a), 32'd0, $sformatf("reset_rd%0d", a));
        check("reset_front", {30'd0, front_sel}, 32'd0);
        check("reset_blank", {31'd0, blank}, 32'd0);
        check("reset_pulse", {31'd0, swap_pulse}, 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(1);

        // Single requested swap and blank width
        bus_write(2'd0, 32'h1, 1'b0);
        tick(2);
        pulse_fe();
        check("s2_front", {30'd0, front_sel}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("s2_blank%0d", i), {31'd0, blank}, {31'd0, (i < 4)});
            check($sformatf("s2_pulse%0d", i), {31'd0, swap_pulse}, {31'd0, (i == 0)});
            tick(1);
        end
        rd_check(2'd1, 32'h10001, "s2_status");
        rd_check(2'd3, 32'd1, "s2_swapcnt");
        rd_check(2'd2, 32'd1, "s2_framecnt");

        // Auto mode with wrap at NUM_BUF=3
        do_reset();
        bus_write(2'd0, 32'h2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(20);
            pulse_fe();
            check($sformatf("s3_front%0d", k), {30'd0, front_sel}, 32'(exp_seq[k]));
        end
        tick(8);
        rd_check(2'd3, 32'd4, "s3_swapcnt");
        rd_check(2'd2, 32'd4, "s3_framecnt");

        // Request coincident with frame_end, then merged requests
        do_reset();
        bus_write(2'd0, 32'h1, 1'b1);
        check("s4_nopulse", {31'd0, swap_pulse}, 32'd0);
        check("s4_front0", {30'd0, front_sel}, 32'd0);
        rd_check(2'd0, 32'd1, "s4_pending");
        bus_write(2'd0, 32'h1, 1'b0);
        bus_write(2'd0, 32'h1, 1'b0);
        pulse_fe();
        tick(8);
        rd_check(2'd3, 32'd1, "s4_swapcnt");
        rd_check(2'd0, 32'd0, "s4_idle");
        check("s4_front1", {30'd0, front_sel}, 32'd1);

        // Request during BLANK, counter clear vs increment, done clear
        do_reset();
        bus_write(2'd0, 32'h1, 1'b0);
        pulse_fe();
        bus_write(2'd0, 32'h1, 1'b0);
        tick(6);
        rd_check(2'd0, 32'd1, "s5_rearmed");
        pulse_fe();
        check("s5_front2", {30'd0, front_sel}, 32'd2);
        tick(6);
        bus_write(2'd2, 32'h0, 1'b1);
        rd_check(2'd2, 32'd0, "s5_frameclr");
        rd_check(2'd3, 32'd2, "s5_swapcnt");
        bus_write(2'd0, 32'h1, 1'b0);
        pulse_fe();
        check("s5_wrap", {30'd0, front_sel}, 32'd0);
        tick(6);
        rd_check(2'd1, 32'h10000, "s5_status_done");
        bus_write(2'd1, 32'h10000, 1'b0);
        rd_check(2'd1, 32'h0, "s5_status_clr");
        bus_write(2'd3, 32'h5, 1'b0);
        rd_check(2'd3, 32'd0, "s5_swapclr");

        // Interrupt mask bit
        do_reset();
`ifdef DISPLAY_SWAP_IRQ_EN
        bus_write(2'd0, 32'h5, 1'b0);
        pulse_fe();
        check("s6_irq_set", {31'd0, irq}, 32'd1);
        rd_check(2'd0, 32'h4, "s6_ctrl_mask");
        tick(6);
        bus_write(2'd1, 32'h10000, 1'b0);
        check("s6_irq_clr", {31'd0, irq}, 32'd0);
`else
        bus_write(2'd0, 32'h4, 1'b0);
        rd_check(2'd0, 32'h0, "s6_ctrl_nomask");
`endif

        // Asynchronous reset in the middle of blanking
        do_reset();
        bus_write(2'd0, 32'h1, 1'b0);
        pulse_fe();
        tick(1);
        check("s7_blank_before", {31'd0, blank}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("s7_blank_rst", {31'd0, blank}, 32'd0);
        check("s7_front_rst", {30'd0, front_sel}, 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_buffer_swap_ctrl.md
Name: display_buffer_swap_ctrl

Overview:
- Avalon-MM slave controller that sequences front/back frame-buffer swaps for the LED tile scan engine.
- The CPU writes a swap request; the block waits for the scan engine's frame boundary, advances the front-buffer select, and blanks the panel for a fixed number of cycles.
- It also keeps frame and swap counters. It sits between the Nios register bus and the display buffer mux / scan engine.

Parameters:
- NUM_BUF, 2, number of frame buffers (2..4); front_sel wraps modulo NUM_BUF.
- BUF_W, 2, width of front_sel (must satisfy 2^BUF_W >= NUM_BUF).
- BLANK_CYCLES, 4, clk cycles blank is held after a swap (>=1).
- CNT_W, 16, width of frame and swap counters (<=16).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data, zero wait states
- frame_end  in  1  one-cycle pulse from scan engine at end of frame, synchronous to clk
- front_sel  out  BUF_W  buffer index currently scanned out
- blank  out  1  panel blank, high during swap blanking
- swap_pulse  out  1  one-cycle pulse on the cycle front_sel changes
- irq  out  1  present only with DISPLAY_SWAP_IRQ_EN

Behaviour:
- Reset values (async on reset_n low): state IDLE, front_sel 0, blank 0, swap_pulse 0, counters 0, auto 0, req_latch 0, done 0, irq 0.
- Write strobe is chipselect & ~write_n. Reads are combinational on address; unused bits read 0.
- addr0 CTRL
  - Write: bit0=1 posts swap request (self-clearing); bit1 = auto mode (swap every frame).
  - Read: bit0 = request pending (state ARMED or req_latch), bit1 = auto.
- addr1 STATUS
  - Read: [BUF_W-1:0] front_sel, bit8 state==BLANK, bit16 done (sticky, set on every swap).
  - Write: bit16=1 clears done.
- addr2 FRAME_CNT
  - Read: frames seen, zero-extended; increments on every frame_end and wraps at 2^CNT_W.
  - Write: any value clears it; a clear wins over a same-cycle increment.
- addr3 SWAP_CNT
  - Read: swaps completed; increments on swap_pulse and wraps.
  - Write: any value clears it; a clear wins over a same-cycle increment.
- FSM states IDLE, ARMED, BLANK:
  - IDLE -> ARMED: on request write or auto=1. A frame_end in the same cycle as the request write is NOT consumed; the swap waits for the next frame_end.
  - ARMED -> BLANK: on frame_end.
    - In the same clock edge: front_sel <= (front_sel==NUM_BUF-1) ? 0 : front_sel+1.
    - swap_pulse=1 for that one cycle (registered, aligned with the new front_sel); blank=1; blank counter loaded with BLANK_CYCLES-1; done set.
    - Further request writes while ARMED merge (no queueing).
  - BLANK: counter decrements each cycle; blank stays 1 for exactly BLANK_CYCLES cycles.
    - A request write during BLANK sets req_latch.
    - frame_end during BLANK only increments FRAME_CNT.
  - BLANK exit when counter==0:
    - If req_latch or auto: go to ARMED and clear req_latch.
    - Otherwise: go to IDLE; blank goes 0.
- Clearing auto while ARMED with no explicit request: remains ARMED (the swap completes). The request cannot be cancelled.
- Reset mid-BLANK: blank drops immediately (async); front_sel returns to 0.

Optional Feature:
- DISPLAY_SWAP_IRQ_EN defined:
  - irq port exists; irq = done & irq_mask.
  - CTRL bit2 = irq_mask (R/W, reset 0).
  - irq is level, cleared by writing STATUS bit16.
- Undefined:
  - No irq port.
  - CTRL bit2 writes ignored and reads 0.
  - done is polled only.

Test Plan:
- Reset, read all addrs -> readdata 0, front_sel 0, blank 0, swap_pulse 0.
- Write CTRL=1, pulse frame_end 3 cycles later -> swap_pulse one cycle at frame_end+1 edge, front_sel 0->1, blank high exactly 4 cycles, STATUS reads 0x10001, SWAP_CNT=1.
- NUM_BUF=3, auto=1, 4 frame_end pulses 20 cycles apart -> front_sel sequence 1,2,0,1; SWAP_CNT=4; FRAME_CNT=4.
- Request write coincident with frame_end in IDLE -> no swap that cycle; swap on next frame_end. Two request writes while ARMED -> single swap, SWAP_CNT=1.
- Request write during BLANK -> after blank ends, state ARMED (CTRL bit0=1); next frame_end swaps again. Write FRAME_CNT coincident with frame_end -> reads 0.
- DISPLAY_SWAP_IRQ_EN, mask=1, one swap -> irq=1 after swap_pulse. Write STATUS 0x10000 -> irq=0. Assert reset_n low during BLANK -> blank 0 immediately, front_sel 0.
